// File: rtl/demux_capture16_pkg.sv
// Shared types and default sizing for the demux_capture16 serial-to-parallel capture block.
package demux_capture16_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_bit_steer.sv
// Combinational bit steer: returns the word with only the addressed position replaced.
module demux_bit_steer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             bit_in,
  input  logic [SEL_W-1:0] pos,
  input  logic             en,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word
);

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    next_word = word;
    if (en) next_word[pos] = bit_in;
  end

endmodule

// File: rtl/demux_capture16.sv
// 1-to-WIDTH demultiplexer with registered output word: addressed writes in IDLE,
// LSB-first scan capture of a full frame with a one-cycle done pulse.
module demux_capture16
  import demux_capture16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = DEFAULT_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic [SEL_W-1:0] S,
  input  logic             wr,
  input  logic             scan_start,
  input  logic             din_valid,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] cnt
);

  state_t           state, state_nxt;
  logic             steer_en;
  logic [SEL_W-1:0] steer_pos;
  logic [WIDTH-1:0] y_steered;
  logic             last_bit;

  assign last_bit = (cnt == SEL_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_start) state_nxt = SCAN;
      SCAN:    if (din_valid && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    busy = (state == SCAN) || (state == DONE);
    done = (state == DONE);
  end

  // One steer serves both paths; scan_start beats a same-cycle addressed write.
  always_comb begin
    steer_en  = 1'b0;
    steer_pos = S;
    case (state)
      IDLE: steer_en = wr && !scan_start;
      SCAN: begin
        steer_en  = din_valid;
        steer_pos = cnt;
      end
      default: ;
    endcase
  end

  demux_bit_steer #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_steer (
    .bit_in   (D),
    .pos      (steer_pos),
    .en       (steer_en),
    .word     (Y),
    .next_word(y_steered)
  );

  // The counter wraps naturally to 0 after the last position since WIDTH == 2**SEL_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            Y   <= '0;
            cnt <= '0;
          end else begin
            Y <= y_steered;
          end
        end
        SCAN: begin
          Y <= y_steered;
          if (din_valid) cnt <= cnt + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_capture16.sv
// Scoreboard bench for demux_capture16: frames are queued at stimulus time and checked on done.
module tb_demux_capture16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        D = 1'b0;
  logic [3:0]  S = '0;
  logic        wr = 1'b0;
  logic        scan_start = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] Y;
  logic        busy;
  logic        done;
  logic [3:0]  cnt;

  demux_capture16 dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .S         (S),
    .wr        (wr),
    .scan_start(scan_start),
    .din_valid (din_valid),
    .Y         (Y),
    .busy      (busy),
    .done      (done),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    int          done_cyc;
  } frame_t;

  frame_t sb[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     busy_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued frame and its cycle.
  always @(negedge clk) begin
    if (busy_chk) begin
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
      busy_chk = 1'b0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        frame_t e;
        e = sb.pop_front();
        check("frame_y", {16'd0, Y}, {16'd0, e.y});
        check("done_cycle", cyc, e.done_cyc);
        busy_chk = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] s, input logic d);
    wr = 1'b1; S = s; D = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic scan_bit(input logic d);
    din_valid = 1'b1; D = d;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_y;
    logic [15:0] frame;
    frame_t      f;

    // Reset state
    #2;
    check("reset_y", {16'd0, Y}, 32'd0);
    check("reset_flags", {28'd0, cnt, busy, done} , 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Addressed walk
    exp_y = '0;
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), 1'b1);
      exp_y[i] = 1'b1;
      check($sformatf("walk_%0d", i), {16'd0, Y}, {16'd0, exp_y});
    end
    check("walk_full", {16'd0, Y}, 32'h0000_FFFF);
    do_write(4'd5, 1'b0);
    check("walk_clear5", {16'd0, Y}, 32'h0000_FFDF);

    // Full back-to-back scan of A5C3: done on the 17th edge after scan_start is driven
    frame = 16'hA5C3;
    f.y = frame; f.done_cyc = cyc + 17;
    sb.push_back(f);
    start_scan();
    check("scan_clears_y", {16'd0, Y}, 32'd0);
    check("scan_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) scan_bit(frame[i]);
    tick();
    check("wrap_cnt", {28'd0, cnt}, 32'd0);

    // Immediate second scan of 0001
    frame = 16'h0001;
    f.y = frame; f.done_cyc = cyc + 17;
    sb.push_back(f);
    start_scan();
    for (int i = 0; i < 16; i++) scan_bit(frame[i]);
    tick();
    check("second_y", {16'd0, Y}, 32'h0000_0001);

    // Gapped scan: first valid captured two edges after scan_start is driven, done 30 edges later
    frame = 16'hA5C3;
    f.y = frame; f.done_cyc = cyc + 2 + 30;
    sb.push_back(f);
    start_scan();
    for (int i = 0; i < 16; i++) begin
      scan_bit(frame[i]);
      if (i < 15) tick();
    end
    tick();
    check("gap_y", {16'd0, Y}, 32'h0000_A5C3);

    // Collision in IDLE: scan_start wins, write dropped
    scan_start = 1'b1; wr = 1'b1; S = 4'd0; D = 1'b1;
    tick();
    scan_start = 1'b0; wr = 1'b0;
    check("collide_idle_y", {16'd0, Y}, 32'd0);
    check("collide_idle_busy", {31'd0, busy}, 32'd1);
    // Collision in SCAN: wr and scan_start ignored
    frame = 16'h1234;
    for (int i = 0; i < 4; i++) scan_bit(frame[i]);
    wr = 1'b1; S = 4'd9; D = 1'b1; scan_start = 1'b1;
    tick();
    wr = 1'b0; scan_start = 1'b0;
    check("collide_scan_y", {16'd0, Y}, 32'h0000_0004);
    check("collide_scan_cnt", {28'd0, cnt}, 32'd4);
    for (int i = 4; i < 16; i++) begin
      if (i == 15) begin
        f.y = frame; f.done_cyc = cyc + 1;
        sb.push_back(f);
      end
      scan_bit(frame[i]);
    end
    tick();
    check("collide_frame_y", {16'd0, Y}, 32'h0000_1234);

    // Reset mid-scan at cnt=7: immediate clear, no done pulse
    start_scan();
    for (int i = 0; i < 7; i++) scan_bit(1'b1);
    check("pre_reset_cnt", {28'd0, cnt}, 32'd7);
    check("pre_reset_y", {16'd0, Y}, 32'h0000_007F);
    din_valid = 1'b1; D = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_reset_y", {16'd0, Y}, 32'd0);
    check("async_reset_flags", {28'd0, cnt, busy, done}, 32'd0);
    din_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    do_write(4'd3, 1'b1);
    check("post_reset_write", {16'd0, Y}, 32'h0000_0008);

    repeat (25) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    check("idle_at_end", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
